// File: rtl/round_judge.sv
// round_judge
//   Front end of the game controller. Synchronises and debounces the player's
//   "choose" button, latches both animal choices on an accepted press, judges
//   the round (dog > cat, cat > chicken, chicken > dog, equal = tie) and keeps
//   both scores plus the registered win flags used to pick the winner screen.
//
//   Ports
//     clk            system clock
//     stateReset     synchronous active-high reset, highest priority
//     userChoose     raw choose button (active-high, asynchronous)
//     userResetGame  raw new-game button (active-high, asynchronous)
//     player1Choice  one-hot choice: 001 cat, 010 dog, 100 chicken
//     player2Choice  same encoding as player1Choice
//     player1/2      4-bit scores
//     player1Wins/2  high while the matching score equals WIN_SCORE
//     roundResult    last round: 00 tie, 01 player 1, 10 player 2
//     roundDone      one-cycle pulse when a round has been scored
//     badChoice      last latched round had a non-one-hot choice
module round_judge #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int WIN_SCORE       = 3
) (
  input  logic       clk,
  input  logic       stateReset,
  input  logic       userChoose,
  input  logic       userResetGame,
  input  logic [2:0] player1Choice,
  input  logic [2:0] player2Choice,
  output logic [3:0] player1,
  output logic [3:0] player2,
  output logic       player1Wins,
  output logic       player2Wins,
  output logic [1:0] roundResult,
  output logic       roundDone,
  output logic       badChoice
);

  typedef enum logic [2:0] {IDLE, JUDGE, UPDATE, WAIT_REL, GAMEOVER} state_t;

  localparam logic [1:0] ANIMAL_CAT     = 2'd0;
  localparam logic [1:0] ANIMAL_DOG     = 2'd1;
  localparam logic [1:0] ANIMAL_CHICKEN = 2'd2;

  localparam logic [1:0] RES_TIE = 2'b00;
  localparam logic [1:0] RES_P1  = 2'b01;
  localparam logic [1:0] RES_P2  = 2'b10;

  localparam logic [3:0]       WIN     = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Anything that is not a clean one-hot code falls back to cat.
  function automatic logic [1:0] decode_animal(input logic [2:0] c);
    case (c)
      3'b010:  return ANIMAL_DOG;
      3'b100:  return ANIMAL_CHICKEN;
      default: return ANIMAL_CAT;
    endcase
  endfunction

  function automatic logic is_bad(input logic [2:0] c);
    return !((c == 3'b001) || (c == 3'b010) || (c == 3'b100));
  endfunction

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return ((a == ANIMAL_DOG)     && (b == ANIMAL_CAT))     ||
           ((a == ANIMAL_CAT)     && (b == ANIMAL_CHICKEN)) ||
           ((a == ANIMAL_CHICKEN) && (b == ANIMAL_DOG));
  endfunction

  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    if (beats(a, b)) return RES_P1;
    if (beats(b, a)) return RES_P2;
    return RES_TIE;
  endfunction

  // Two-flop synchronisers for the asynchronous buttons
  logic choose_p0, choose_p1;
  logic newgame_p0, newgame_p1;

  always_ff @(posedge clk) begin
    if (stateReset) begin
      choose_p0  <= 1'b0;
      choose_p1  <= 1'b0;
      newgame_p0 <= 1'b0;
      newgame_p1 <= 1'b0;
    end else begin
      choose_p0  <= userChoose;
      choose_p1  <= choose_p0;
      newgame_p0 <= userResetGame;
      newgame_p1 <= newgame_p0;
    end
  end

  // Debounce: count consecutive cycles with an unchanged synchronised level;
  // the stable level follows the input once that run is long enough.
  logic             choose_prev;
  logic             db_level;
  logic [CNT_W-1:0] db_cnt;
  logic             db_hit;
  logic             press_acc;

  assign db_hit    = (choose_p1 == choose_prev) && (db_cnt == DB_LAST);
  assign press_acc = db_hit && choose_p1 && !db_level;

  always_ff @(posedge clk) begin
    if (stateReset) begin
      choose_prev <= 1'b0;
      db_level    <= 1'b0;
      db_cnt      <= '0;
    end else begin
      choose_prev <= choose_p1;
      if (choose_p1 != choose_prev) db_cnt <= '0;
      else if (db_cnt != DB_MAX)    db_cnt <= db_cnt + 1'b1;
      if (db_hit) db_level <= choose_p1;
    end
  end

  // Round FSM
  state_t     state_q, state_d;
  logic [1:0] c1_q, c2_q, result_q;
  logic [3:0] p1_inc, p2_inc;
  logic       win_hit;

  assign p1_inc  = player1 + 4'd1;
  assign p2_inc  = player2 + 4'd1;
  assign win_hit = ((result_q == RES_P1) && (p1_inc == WIN)) ||
                   ((result_q == RES_P2) && (p2_inc == WIN));

  always_ff @(posedge clk) begin
    if (stateReset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (press_acc) state_d = JUDGE;
      JUDGE:    state_d = UPDATE;
      UPDATE:   state_d = win_hit ? GAMEOVER : WAIT_REL;
      WAIT_REL: if (!db_level) state_d = IDLE;
      GAMEOVER: state_d = GAMEOVER;
      default:  state_d = IDLE;
    endcase
    // A new game aborts whatever is in flight and waits for a button release
    // so a held choose cannot immediately fire a round.
    if (newgame_p1) state_d = WAIT_REL;
  end

  // Choice latch and judged result (data only)
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && press_acc) begin
      c1_q <= decode_animal(player1Choice);
      c2_q <= decode_animal(player2Choice);
    end
    if (state_q == JUDGE) result_q <= judge(c1_q, c2_q);
  end

  // Scores, flags and round outputs
  always_ff @(posedge clk) begin
    if (stateReset) begin
      player1     <= '0;
      player2     <= '0;
      player1Wins <= 1'b0;
      player2Wins <= 1'b0;
      roundResult <= RES_TIE;
      roundDone   <= 1'b0;
      badChoice   <= 1'b0;
    end else begin
      roundDone   <= 1'b0;
      player1Wins <= (player1 == WIN);
      player2Wins <= (player2 == WIN);
      if (newgame_p1) begin
        player1     <= '0;
        player2     <= '0;
        player1Wins <= 1'b0;
        player2Wins <= 1'b0;
        roundResult <= RES_TIE;
        badChoice   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (press_acc) badChoice <= is_bad(player1Choice) | is_bad(player2Choice);
          UPDATE: begin
            roundResult <= result_q;
            if (result_q == RES_P1) player1 <= p1_inc;
            if (result_q == RES_P2) player2 <= p2_inc;
            roundDone <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
